// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-client (icache/dcache) line-fill/writeback arbiter
//               feeding a single memory port through IDLE/ISSUE/WAIT/RESP.
// Optional build macro ARB_FAIRNESS_EN bounds icache starvation.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_dc_q, owner_dc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              grant_dc;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             ic_starved;

  assign ic_starved = (starve_q == CNT_W'(STARVE_MAX));
  assign grant_dc   = dc_req && !(ic_req && ic_starved);

  // Counts only dcache wins taken while icache was also waiting.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (ic_req || dc_req)) begin
      if (grant_dc && ic_req) starve_d = starve_q + CNT_W'(1);
      else                    starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign grant_dc = dc_req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          owner_dc_d = grant_dc;
          we_d       = grant_dc ? dc_we    : 1'b0;
          addr_d     = grant_dc ? dc_addr  : ic_addr;
          wdata_d    = grant_dc ? dc_wdata : '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready) begin
          // Writeback completion returns no line; dcache data stays put.
          if (owner_dc_q) begin
            if (!we_q) dc_rdata_d = mem_rdata;
          end else begin
            ic_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ic_ack    = (state_q == RESP) && !owner_dc_q;
  assign dc_ack    = (state_q == RESP) && owner_dc_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
